// File: rtl/ring_osc_pkg.sv
// Shared types and default parameters for the ring oscillator sequencer/meter.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_WARMUP_CYCLES = 8;
  localparam int DEF_GATE_CYCLES   = 64;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the free-running oscillator output into clk and flags each rising edge
// with a single-cycle pulse.
module ring_edge_sync
  import ring_osc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   prev_reg;

  assign sync_next[0] = async_i;

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // prev_reg is one cycle behind the last synchronizer stage
  assign rise_o = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ring_osc_controller.sv
// Ring oscillator sequencer: enable, warm up, count rising edges over a fixed
// gate window and report the count with overflow/stuck flags.
module ring_osc_controller
  import ring_osc_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             ring_clk_i,
  output logic             ring_en_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             stuck
);

  localparam int PH_W = $clog2(max_int(WARMUP_CYCLES, GATE_CYCLES)) + 1;
  localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
  localparam logic [PH_W-1:0]  WARMUP_LAST = PH_W'(WARMUP_CYCLES - 1);
  localparam logic [PH_W-1:0]  GATE_LAST   = PH_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W:0]   SAT_VAL     = {1'b1, {CNT_W{1'b0}}};

  state_t           state_reg, state_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [CNT_W:0]   work_reg, work_next;
  logic [CNT_W:0]   work_sum;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             stuck_reg;
  logic             done_reg;
  logic             meas_end;
  logic             rise;

  ring_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ring_clk_i),
    .rise_o  (rise)
  );

  // Saturating at 2^CNT_W is enough to flag overflow without wrapping
  assign work_sum = (work_reg == SAT_VAL) ? work_reg
                                          : work_reg + {{CNT_W{1'b0}}, rise};

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    work_next  = work_reg;
    meas_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        phase_next = '0;
        work_next  = '0;
        if (start) state_next = WARMUP;
      end
      WARMUP: begin
        if (phase_reg == WARMUP_LAST) begin
          state_next = MEASURE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PH_ONE;
        end
      end
      MEASURE: begin
        work_next = work_sum;
        if (phase_reg == GATE_LAST) begin
          state_next = DONE;
          phase_next = '0;
          meas_end   = 1'b1;
        end else begin
          phase_next = phase_reg + PH_ONE;
        end
      end
      DONE: begin
        // Edges seen here are dropped; the next window starts from zero
        work_next  = '0;
        phase_next = '0;
        state_next = continuous ? MEASURE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results are captured on the edge into DONE so they appear alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      work_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      stuck_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      work_reg  <= work_next;
      done_reg  <= meas_end;
      if (meas_end) begin
        count_reg    <= work_sum[CNT_W] ? {CNT_W{1'b1}} : work_sum[CNT_W-1:0];
        overflow_reg <= work_sum[CNT_W];
        stuck_reg    <= (work_sum == '0);
      end
    end
  end

  assign ring_en_o = (state_reg != IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign stuck     = stuck_reg;

endmodule
